// File: rtl/reset_request.sv
// Reset request generator: stretches POR/SW/button/watchdog requests into a fixed-width
// active-low pulse followed by a holdoff. Watchdog source present only with RESETGEN_WATCHDOG_EN.
module reset_request #(
    parameter int unsigned PULSE_CYCLES    = 16,
    parameter int unsigned HOLDOFF_CYCLES  = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned WDT_CYCLES      = 1048576
) (
    input  logic       i_clk,
    input  logic       i_areset,
    input  logic       i_btn,
    input  logic       i_sw_req,
    input  logic       i_wdt_kick,
    output logic       o_reset_n,
    output logic [1:0] o_cause,
    output logic       o_busy
);

    localparam int unsigned PulseW = $clog2(PULSE_CYCLES);
    localparam int unsigned HoldW  = $clog2(HOLDOFF_CYCLES);
    localparam int unsigned CntW   = (PulseW > HoldW) ? PulseW : HoldW;
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLDOFF_CYCLES - 1);
    localparam logic [DebW-1:0] DebMax    = DebW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CausePor = 2'd0;
    localparam logic [1:0] CauseSw  = 2'd1;
    localparam logic [1:0] CauseBtn = 2'd2;
    localparam logic [1:0] CauseWdt = 2'd3;

    typedef enum logic [1:0] {StAssert, StHoldoff, StIdle} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              reset_n_q;
    logic              enter_assert;

    logic              btn_s1_q, btn_s2_q;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic              deb_q, deb_d, deb_dly_q;
    logic              btn_req;
    logic              wdt_req;

    // Button: synchronize, debounce, then fire once on the debounced rising edge.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (!btn_s2_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DebMax) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign deb_d   = btn_s2_q && (deb_cnt_q == DebMax);
    assign btn_req = deb_q && !deb_dly_q;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            btn_s1_q  <= i_btn;
            btn_s2_q  <= btn_s1_q;
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

`ifdef RESETGEN_WATCHDOG_EN
    localparam int unsigned WdtW = $clog2(WDT_CYCLES);
    localparam logic [WdtW-1:0] WdtMax = WdtW'(WDT_CYCLES - 1);

    logic            wdt_armed_q;
    logic [WdtW-1:0] wdt_cnt_q;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wdt_armed_q <= 1'b0;
            wdt_cnt_q   <= '0;
        end else begin
            if (enter_assert) begin
                wdt_armed_q <= 1'b0;
            end else if (i_wdt_kick) begin
                wdt_armed_q <= 1'b1;
            end
            if (i_wdt_kick || (state_q != StIdle)) begin
                wdt_cnt_q <= '0;
            end else if (wdt_armed_q && (wdt_cnt_q != WdtMax)) begin
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
            end
        end
    end

    // A kick on the expiry edge wins over the timeout.
    assign wdt_req = wdt_armed_q && (state_q == StIdle) && (wdt_cnt_q == WdtMax) && !i_wdt_kick;
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = i_wdt_kick;
    assign wdt_req         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            StAssert: begin
                if (cnt_q == '0) begin
                    state_d = StHoldoff;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHoldoff: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StIdle: begin
                if (i_sw_req || btn_req || wdt_req) begin
                    state_d = StAssert;
                    cnt_d   = PulseLoad;
                    if (i_sw_req) begin
                        cause_d = CauseSw;
                    end else if (btn_req) begin
                        cause_d = CauseBtn;
                    end else begin
                        cause_d = CauseWdt;
                    end
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = PulseLoad;
            end
        endcase
    end

    assign enter_assert = (state_q == StIdle) && (state_d == StAssert);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= StAssert;
            cnt_q     <= PulseLoad;
            cause_q   <= CausePor;
            reset_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            reset_n_q <= (state_d != StAssert);
        end
    end

    assign o_reset_n = reset_n_q;
    assign o_cause   = cause_q;
    assign o_busy    = (state_q != StIdle);

endmodule
